// File: rtl/fp_div_pkg.sv
// Shared types and format constants for the iterative floating-point divider.
//   state_e      : control FSM states
//   round_mode_e : rounding mode selected with each request
//   FP32_/FP16_  : exponent and stored-mantissa widths of the common formats
`timescale 1ns/1ps
package fp_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef enum logic {
    RM_TRUNC = 1'b0,
    RM_RNE   = 1'b1
  } round_mode_e;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per cycle, MAN_W+3 cycles.
//   clk, reset : clock, synchronous active-high reset
//   start      : load dividend/divisor (1.m form) and begin iterating
//   dividend   : MAN_W+1 bits, hidden one included
//   divisor    : MAN_W+1 bits, hidden one included
//   quotient   : MAN_W+3 bits, MSB is the integer bit of the quotient
//   rem_nz     : final partial remainder is nonzero
//   done       : high during the cycle that produces the last quotient bit
`timescale 1ns/1ps
module fp_div_mant_core #(
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic [MAN_W+2:0] quotient,
  output logic             rem_nz,
  output logic             done
);

  localparam int STEPS = MAN_W + 3;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  logic [MAN_W+1:0] rem_r;
  logic [MAN_W:0]   den_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic [MAN_W+2:0] q_r;
  logic [MAN_W+2:0] diff_s;
  logic             ge_s;
  logic [MAN_W+1:0] rem_next_s;

  // Trial subtraction; the extra top bit of diff_s is the borrow.
  always_comb begin
    diff_s = {1'b0, rem_r} - {2'b00, den_r};
    ge_s   = ~diff_s[MAN_W+2];
    if (ge_s) begin
      rem_next_s = diff_s[MAN_W+1:0];
    end else begin
      rem_next_s = rem_r;
    end
  end

  assign done     = run_r && (cnt_r == LAST_CNT);
  assign quotient = q_r;
  assign rem_nz   = |rem_r;

  // Iteration state: load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= {(MAN_W+2){1'b0}};
      den_r <= {(MAN_W+1){1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      run_r <= 1'b0;
      q_r   <= {(MAN_W+3){1'b0}};
    end else if (start) begin
      rem_r <= {1'b0, dividend};
      den_r <= divisor;
      cnt_r <= {CNT_W{1'b0}};
      run_r <= 1'b1;
      q_r   <= {(MAN_W+3){1'b0}};
    end else if (run_r) begin
      // Remainder after a restore is below the divisor, so the top bit is free for the shift.
      rem_r <= {rem_next_s[MAN_W:0], 1'b0};
      q_r   <= {q_r[MAN_W+1:0], ge_s};
      cnt_r <= cnt_r + CNT_W'(1);
      if (done) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_divider_iter.sv
// Iterative IEEE-style floating-point divider (subnormals flushed to zero).
//   clk, reset   : clock, synchronous active-high reset
//   A, B         : dividend, divisor (sign | exponent | mantissa)
//   En           : start request, honoured only while Busy is low
//   RoundMode    : 0 truncate, 1 round-to-nearest-even, captured with En
//   Result       : quotient, held until the next completion
//   Ready        : one-cycle completion pulse
//   Busy         : high from the accepting edge until Ready drops
//   NaN, DivByZero, Overflow, Underflow, Inexact : status of the last result
// Result, flags and Ready are registered from the DONE state, so they appear
// on the edge that leaves DONE.
`timescale 1ns/1ps
module fp_divider_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = FP32_EXP_W,
  parameter int MAN_W = FP32_MAN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   En,
  input  logic                   RoundMode,
  output logic [EXP_W+MAN_W:0]   Result,
  output logic                   Ready,
  output logic                   Busy,
  output logic                   NaN,
  output logic                   DivByZero,
  output logic                   Overflow,
  output logic                   Underflow,
  output logic                   Inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};

  state_e            state_r, state_s;
  logic [W-1:0]      a_r, b_r;
  round_mode_e       mode_r;
  logic              sign_r;
  logic signed [EW-1:0] exp_r;
  logic [MAN_W:0]    mant_r;
  logic              guard_r, sticky_r;
  logic [W-1:0]      pend_res_r;
  logic [4:0]        pend_flags_r;   // {nan, div_by_zero, overflow, underflow, inexact}

  logic              accept_s;
  logic              sign_a_s, sign_b_s, sign_q_s;
  logic [EXP_W-1:0]  exp_a_s, exp_b_s;
  logic [MAN_W-1:0]  man_a_s, man_b_s;
  logic              a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;
  logic              special_s;
  logic [W-1:0]      spec_res_s;
  logic [4:0]        spec_flags_s;
  logic signed [EW-1:0] exp_diff_s;
  logic [MAN_W+2:0]  q_s;
  logic              rem_nz_s, core_done_s, core_start_s;
  logic [MAN_W:0]    norm_mant_s;
  logic              norm_guard_s, norm_sticky_s;
  logic signed [EW-1:0] norm_exp_s, exp_fin_s;
  logic              rnd_inc_s, inexact_s;
  logic [MAN_W+1:0]  rnd_sum_s;
  logic [MAN_W-1:0]  rnd_frac_s;
  logic [W-1:0]      rnd_res_s;
  logic [4:0]        rnd_flags_s;

  assign accept_s = (state_r == IDLE) && En && !Busy;

  assign sign_a_s = a_r[W-1];
  assign sign_b_s = b_r[W-1];
  assign sign_q_s = sign_a_s ^ sign_b_s;
  assign exp_a_s  = a_r[W-2:MAN_W];
  assign exp_b_s  = b_r[W-2:MAN_W];
  assign man_a_s  = a_r[MAN_W-1:0];
  assign man_b_s  = b_r[MAN_W-1:0];
  assign a_nan_s  = (exp_a_s == EXP_ONES) && (|man_a_s);
  assign a_inf_s  = (exp_a_s == EXP_ONES) && !(|man_a_s);
  assign a_zero_s = (exp_a_s == {EXP_W{1'b0}});   // subnormals count as zero
  assign b_nan_s  = (exp_b_s == EXP_ONES) && (|man_b_s);
  assign b_inf_s  = (exp_b_s == EXP_ONES) && !(|man_b_s);
  assign b_zero_s = (exp_b_s == {EXP_W{1'b0}});

  assign exp_diff_s   = $signed({2'b00, exp_a_s}) - $signed({2'b00, exp_b_s}) + BIAS;
  assign core_start_s = (state_r == UNPACK) && !special_s;

  // Special-operand classification, in priority order.
  always_comb begin
    special_s    = 1'b1;
    spec_res_s   = {W{1'b0}};
    spec_flags_s = 5'b00000;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_res_s   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags_s = 5'b10000;
    end else if (a_inf_s) begin
      spec_res_s = {sign_q_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_zero_s) begin
      spec_res_s   = {sign_q_s, EXP_ONES, {MAN_W{1'b0}}};
      spec_flags_s = 5'b01000;
    end else if (b_inf_s || a_zero_s) begin
      spec_res_s = {sign_q_s, {(W-1){1'b0}}};
    end else begin
      special_s = 1'b0;
    end
  end

  fp_div_mant_core #(.MAN_W(MAN_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (core_start_s),
    .dividend ({1'b1, man_a_s}),
    .divisor  ({1'b1, man_b_s}),
    .quotient (q_s),
    .rem_nz   (rem_nz_s),
    .done     (core_done_s)
  );

  // Normalisation: a quotient below one is shifted left by a single place.
  always_comb begin
    if (q_s[MAN_W+2]) begin
      norm_mant_s   = q_s[MAN_W+2:2];
      norm_guard_s  = q_s[1];
      norm_sticky_s = q_s[0] | rem_nz_s;
      norm_exp_s    = exp_r;
    end else begin
      norm_mant_s   = q_s[MAN_W+1:1];
      norm_guard_s  = q_s[0];
      norm_sticky_s = rem_nz_s;
      norm_exp_s    = exp_r - EXP_ONE;
    end
  end

  // Rounding, carry renormalisation and range limiting.
  always_comb begin
    rnd_inc_s = (mode_r == RM_RNE) && guard_r && (sticky_r || mant_r[0]);
    rnd_sum_s = {1'b0, mant_r} + {{(MAN_W+1){1'b0}}, rnd_inc_s};
    inexact_s = guard_r | sticky_r;
    if (rnd_sum_s[MAN_W+1]) begin
      rnd_frac_s = rnd_sum_s[MAN_W:1];
      exp_fin_s  = exp_r + EXP_ONE;
    end else begin
      rnd_frac_s = rnd_sum_s[MAN_W-1:0];
      exp_fin_s  = exp_r;
    end
    if (exp_fin_s >= EXP_MAX) begin
      rnd_res_s   = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      rnd_flags_s = 5'b00101;
    end else if (exp_fin_s <= EXP_ZERO) begin
      rnd_res_s   = {sign_r, {(W-1){1'b0}}};
      rnd_flags_s = 5'b00011;
    end else begin
      rnd_res_s   = {sign_r, exp_fin_s[EXP_W-1:0], rnd_frac_s};
      rnd_flags_s = {4'b0000, inexact_s};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = UNPACK; else state_s = IDLE;
      UNPACK:  if (special_s) state_s = DONE; else state_s = DIVIDE;
      DIVIDE:  if (core_done_s) state_s = NORM; else state_s = DIVIDE;
      NORM:    state_s = ROUND;
      ROUND:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and per-stage datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      mode_r       <= RM_TRUNC;
      sign_r       <= 1'b0;
      exp_r        <= EXP_ZERO;
      mant_r       <= {(MAN_W+1){1'b0}};
      guard_r      <= 1'b0;
      sticky_r     <= 1'b0;
      pend_res_r   <= {W{1'b0}};
      pend_flags_r <= 5'b00000;
    end else begin
      if (accept_s) begin
        a_r    <= A;
        b_r    <= B;
        mode_r <= round_mode_e'(RoundMode);
      end
      case (state_r)
        UNPACK: begin
          sign_r <= sign_q_s;
          exp_r  <= exp_diff_s;
          if (special_s) begin
            pend_res_r   <= spec_res_s;
            pend_flags_r <= spec_flags_s;
          end
        end
        NORM: begin
          mant_r   <= norm_mant_s;
          guard_r  <= norm_guard_s;
          sticky_r <= norm_sticky_s;
          exp_r    <= norm_exp_s;
        end
        ROUND: begin
          pend_res_r   <= rnd_res_s;
          pend_flags_r <= rnd_flags_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: published from DONE, Busy spans accept through Ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      Result    <= {W{1'b0}};
      Ready     <= 1'b0;
      Busy      <= 1'b0;
      NaN       <= 1'b0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Inexact   <= 1'b0;
    end else begin
      Ready <= (state_r == DONE);
      if (state_r == DONE) begin
        Result <= pend_res_r;
        {NaN, DivByZero, Overflow, Underflow, Inexact} <= pend_flags_r;
      end
      if (accept_s) begin
        Busy <= 1'b1;
      end else if (Ready) begin
        Busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_divider_iter.sv
// Directed self-checking bench for fp_divider_iter (FP32 and FP16 instances).
`timescale 1ns/1ps
module tb_fp_divider_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, Result;
  logic        En, RoundMode, Ready, Busy;
  logic        NaN, DivByZero, Overflow, Underflow, Inexact;

  logic [15:0] h_a, h_b, h_res;
  logic        h_en, h_mode, h_ready, h_busy;
  logic        h_nan, h_dbz, h_ovf, h_unf, h_inx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_divider_iter dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .En(En), .RoundMode(RoundMode),
    .Result(Result), .Ready(Ready), .Busy(Busy), .NaN(NaN), .DivByZero(DivByZero),
    .Overflow(Overflow), .Underflow(Underflow), .Inexact(Inexact)
  );

  fp_divider_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .A(h_a), .B(h_b), .En(h_en), .RoundMode(h_mode),
    .Result(h_res), .Ready(h_ready), .Busy(h_busy), .NaN(h_nan), .DivByZero(h_dbz),
    .Overflow(h_ovf), .Underflow(h_unf), .Inexact(h_inx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One FP32 operation. At edge 'poke' after accept a second request with
  // different operands is driven; it must be ignored. Latency is -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mode,
                       input int poke, output logic [31:0] res, output logic [4:0] flg,
                       output int lat);
    for (int k = 0; k < 50 && Busy; k++) @(negedge clk);
    @(negedge clk);
    A = a; B = b; RoundMode = mode; En = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", {31'd0, Busy}, 32'd1);
    En = 1'b0; A = 32'hDEADBEEF; B = 32'h12345678; RoundMode = ~mode;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == poke) begin
        A = 32'h3F800000; B = 32'h40400000; En = 1'b1;
      end else begin
        En = 1'b0;
      end
      @(posedge clk); #1;
      if (Ready) begin
        lat = n;
        break;
      end
    end
    En  = 1'b0;
    res = Result;
    flg = {NaN, DivByZero, Overflow, Underflow, Inexact};
  endtask

  logic [31:0] res;
  logic [4:0]  flg;
  int          lat;
  int          rdy_cnt;

  initial begin
    // Reset with a request pending: nothing may start.
    reset = 1'b1; En = 1'b1; A = 32'h40A00000; B = 32'h3F800000; RoundMode = 1'b0;
    h_en = 1'b1; h_a = 16'h3C00; h_b = 16'h4000; h_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", Result, 32'h0);
    chk("rst_ready_busy", {30'd0, Ready, Busy}, 32'h0);
    chk("rst_flags", {27'd0, NaN, DivByZero, Overflow, Underflow, Inexact}, 32'h0);
    @(negedge clk);
    reset = 1'b0; En = 1'b0; h_en = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);

    // FP16 instance: 1.0 / 2.0 = 0.5, 13 divide cycles.
    @(negedge clk);
    h_a = 16'h3C00; h_b = 16'h4000; h_mode = 1'b0; h_en = 1'b1;
    @(posedge clk); #1;
    h_en = 1'b0; lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (h_ready) begin
        lat = n;
        break;
      end
    end
    chk("h_result", {16'd0, h_res}, 32'h00003800);
    chk("h_latency", lat, 32'd17);
    chk("h_flags", {27'd0, h_nan, h_dbz, h_ovf, h_unf, h_inx}, 32'h0);

    // -2 / 0.75 = -2.666..., guard=1 sticky=1.
    do_op(32'hC0000000, 32'h3F400000, 1'b0, 0, res, flg, lat);
    chk("m2_trunc_res", res, 32'hC02AAAAA);
    chk("m2_trunc_flags", {27'd0, flg}, 32'h1);
    chk("m2_trunc_lat", lat, 32'd30);
    do_op(32'hC0000000, 32'h3F400000, 1'b1, 0, res, flg, lat);
    chk("m2_rne_res", res, 32'hC02AAAAB);
    chk("m2_rne_lat", lat, 32'd30);

    // 1 / 3.
    do_op(32'h3F800000, 32'h40400000, 1'b0, 0, res, flg, lat);
    chk("third_trunc_res", res, 32'h3EAAAAAA);
    do_op(32'h3F800000, 32'h40400000, 1'b1, 0, res, flg, lat);
    chk("third_rne_res", res, 32'h3EAAAAAB);

    // 1.5 / -2 = -0.75 exactly; sign is the XOR of the operand signs.
    do_op(32'h3FC00000, 32'hC0000000, 1'b1, 0, res, flg, lat);
    chk("exact_res", res, 32'hBF400000);
    chk("exact_flags", {27'd0, flg}, 32'h0);

    // Special cases complete two edges after accept.
    do_op(32'h00000000, 32'h00000000, 1'b0, 0, res, flg, lat);
    chk("zero_zero_res", res, 32'h7FC00000);
    chk("zero_zero_flags", {27'd0, flg}, 32'h10);
    chk("zero_zero_lat", lat, 32'd2);
    do_op(32'h40A00000, 32'h00000000, 1'b0, 0, res, flg, lat);
    chk("div0_res", res, 32'h7F800000);
    chk("div0_flags", {27'd0, flg}, 32'h08);
    chk("div0_lat", lat, 32'd2);

    // Range limits.
    do_op(32'h7F7FFFFF, 32'h3F000000, 1'b1, 0, res, flg, lat);
    chk("ovf_res", res, 32'h7F800000);
    chk("ovf_flags", {27'd0, flg}, 32'h05);
    do_op(32'h00800000, 32'h7F7FFFFF, 1'b1, 0, res, flg, lat);
    chk("unf_res", res, 32'h00000000);
    chk("unf_flags", {27'd0, flg}, 32'h03);

    // Second request while dividing must not disturb the first.
    do_op(32'hC0000000, 32'h3F400000, 1'b0, 5, res, flg, lat);
    chk("ignore_en_res", res, 32'hC02AAAAA);
    chk("ignore_en_lat", lat, 32'd30);

    // Reset ten edges into an operation.
    @(negedge clk);
    A = 32'hC0000000; B = 32'h3F400000; RoundMode = 1'b1; En = 1'b1;
    @(posedge clk); #1;
    En = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_result", Result, 32'h0);
    chk("midrst_ctrl", {30'd0, Ready, Busy}, 32'h0);
    chk("midrst_flags", {27'd0, NaN, DivByZero, Overflow, Underflow, Inexact}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Ready) rdy_cnt++;
    end
    chk("midrst_no_ready", rdy_cnt, 32'd0);
    do_op(32'h3F800000, 32'h40400000, 1'b1, 0, res, flg, lat);
    chk("after_rst_res", res, 32'h3EAAAAAB);
    chk("after_rst_lat", lat, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
